// File: rtl/io_pkg.sv
// io_pkg: shared register map, status bit layout and default timing for io_port_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_pkg;

  // Word addresses (CPU address bits [3:2]); word 3 is unmapped.
  localparam logic [1:0] IO_ADDR_STATUS = 2'd0;
  localparam logic [1:0] IO_ADDR_SWITCH = 2'd1;
  localparam logic [1:0] IO_ADDR_LED    = 2'd2;

  // STATUS register bit positions.
  localparam int SW_READY_BIT  = 0;
  localparam int LED_READY_BIT = 1;

  // 10 ms of stable level at 100 MHz; the counter must be able to reach DEBOUNCE_CYCLES-1.
  localparam int DEBOUNCE_CYCLES_DFLT = 1_000_000;
  localparam int CNT_W_DFLT           = 20;

  // Field order matches SW_READY_BIT / LED_READY_BIT when packed into the read word.
  typedef struct packed {
    logic led_ready;
    logic sw_ready;
  } status_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer + stability counter + rising-edge press pulse for one raw button.
// Latency: raw edge to press_vld = 2 sync cycles + DEBOUNCE_CYCLES; press_vld is combinational from flops.
// Backpressure: none; press_vld is a 1-cycle pulse that the consumer must take when it appears.
// Ports: clk, reset (sync, active-high), btn (raw async level), press_vld (1-cycle press pulse).
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int CNT_W           = CNT_W_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_vld
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;    // accepted (debounced) level
  logic             level_q;  // accepted level one cycle ago, for edge detection
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // Count only while the synchronized level disagrees with the accepted one;
      // any return to agreement restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press_vld = level & ~level_q;

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped button/switch/LED peripheral with pollable ready flags.
// Latency: reads are combinational; writes land at the clock edge with pWrite=1.
// Backpressure: none; the CPU polls sw_ready/led_ready and clears them by W1C.
// Ports: clk, reset (sync, active-high); pRead/pWrite/addr/pWriteData/pReadData decoder side;
//        buttonL/buttonR raw buttons, switch raw slide switches, led display register.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int CNT_W           = CNT_W_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pRead,
  input  logic        pWrite,
  input  logic [1:0]  addr,
  input  logic [11:0] pWriteData,
  output logic [31:0] pReadData,
  input  logic        buttonL,
  input  logic        buttonR,
  input  logic [15:0] switch,
  output logic [11:0] led
);

  logic        press_l_vld;
  logic        press_r_vld;
  logic [15:0] sw_sync1;
  logic [15:0] sw_sync2;
  logic [15:0] sw_reg;
  status_t     status;
  logic        status_wr;
  logic        led_wr;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_l (
    .clk       (clk),
    .reset     (reset),
    .btn       (buttonL),
    .press_vld (press_l_vld)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_r (
    .clk       (clk),
    .reset     (reset),
    .btn       (buttonR),
    .press_vld (press_r_vld)
  );

  assign status_wr = pWrite && (addr == IO_ADDR_STATUS);
  assign led_wr    = pWrite && (addr == IO_ADDR_LED);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1         <= '0;
      sw_sync2         <= '0;
      sw_reg           <= '0;
      led              <= '0;
      status.sw_ready  <= 1'b0;
      status.led_ready <= 1'b0;
    end else begin
      // The switch bus is only sampled on a press, long after it settled, so a
      // plain per-bit synchronizer is enough to keep metastability out of sw_reg.
      sw_sync1 <= switch;
      sw_sync2 <= sw_sync1;

      if (led_wr) begin
        led <= pWriteData;
      end

      // A press and a clear in the same cycle resolve to set, so an event is never lost.
      if (press_r_vld) begin
        sw_reg          <= sw_sync2;
        status.sw_ready <= 1'b1;
      end else if (status_wr && pWriteData[SW_READY_BIT]) begin
        status.sw_ready <= 1'b0;
      end

      if (press_l_vld) begin
        status.led_ready <= 1'b1;
      end else if (led_wr || (status_wr && pWriteData[LED_READY_BIT])) begin
        status.led_ready <= 1'b0;
      end
    end
  end

  always_comb begin
    pReadData = '0;
    if (pRead) begin
      case (addr)
        IO_ADDR_STATUS: pReadData = {30'b0, status};
        IO_ADDR_SWITCH: pReadData = {16'b0, sw_reg};
        IO_ADDR_LED:    pReadData = {20'b0, led};
        default:        pReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [11:0] pWriteData;
  logic [31:0] pReadData;
  logic        buttonL;
  logic        buttonR;
  logic [15:0] switch;
  logic [11:0] led;

  io_port_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pRead      (pRead),
    .pWrite     (pWrite),
    .addr       (addr),
    .pWriteData (pWriteData),
    .pReadData  (pReadData),
    .buttonL    (buttonL),
    .buttonR    (buttonR),
    .switch     (switch),
    .led        (led)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural reference model ----------------
  // Buttons: a level is accepted once D consecutive synchronized samples
  // (raw delayed by two edges) disagree with the accepted level.
  logic [11:0] m_led;
  logic [15:0] m_sw;
  bit          m_swr;
  bit          m_ledr;
  bit          hist[2][$];   // raw button samples still in flight through the synchronizer
  bit          m_acc[2];
  int          streak[2];
  bit          pend[2];      // accepted level rose at the previous edge
  logic [15:0] sw_hist[$];

  task automatic model_reset();
    m_led  = '0;
    m_sw   = '0;
    m_swr  = 1'b0;
    m_ledr = 1'b0;
    for (int b = 0; b < 2; b++) begin
      hist[b]   = '{1'b0, 1'b0};
      m_acc[b]  = 1'b0;
      streak[b] = 0;
      pend[b]   = 1'b0;
    end
    sw_hist = '{16'h0, 16'h0};
  endtask

  task automatic model_edge();
    bit          raw[2];
    bit          v;
    logic [15:0] sv;
    raw[0] = buttonL;
    raw[1] = buttonR;
    if (reset) begin
      model_reset();
      return;
    end
    sv = sw_hist.pop_front();
    sw_hist.push_back(switch);
    if (pWrite && addr == 2'd0 && pWriteData[0]) m_swr = 1'b0;
    if (pWrite && addr == 2'd0 && pWriteData[1]) m_ledr = 1'b0;
    if (pWrite && addr == 2'd2) begin
      m_led  = pWriteData;
      m_ledr = 1'b0;
    end
    if (pend[1]) begin
      m_sw  = sv;
      m_swr = 1'b1;
    end
    if (pend[0]) m_ledr = 1'b1;
    for (int b = 0; b < 2; b++) begin
      v = hist[b].pop_front();
      hist[b].push_back(raw[b]);
      pend[b] = 1'b0;
      if (v != m_acc[b]) begin
        streak[b]++;
        if (streak[b] == D) begin
          m_acc[b]  = v;
          streak[b] = 0;
          pend[b]   = v;
        end
      end else begin
        streak[b] = 0;
      end
    end
  endtask

  function automatic logic [31:0] m_rdata();
    if (!pRead) return 32'h0;
    case (addr)
      2'd0:    return {30'b0, m_ledr, m_swr};
      2'd1:    return {16'b0, m_sw};
      2'd2:    return {20'b0, m_led};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    chk("model_rdata", pReadData, m_rdata());
    chk("model_led", {20'b0, led}, {20'b0, m_led});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    pRead = 1'b1;
    addr  = a;
    #1;
    chk(nm, pReadData, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [11:0] d);
    pWrite     = 1'b1;
    addr       = a;
    pWriteData = d;
    tick();
    pWrite = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [11:0] wd;
    logic [31:0] exp_rd;   // read value before the edge
    logic [11:0] exp_led;  // led after the edge
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at;
    int rises;
    int hold_l;
    int hold_r;
    logic prev;

    reset = 1'b1; pRead = 1'b0; pWrite = 1'b0; addr = 2'd0; pWriteData = '0;
    buttonL = 1'b0; buttonR = 1'b0; switch = '0;
    model_reset();

    // ---- reset check ----
    ticks(2);
    reset = 1'b0;
    chk("reset_status", {20'b0, led}, 32'h0);
    chk_rd("reset_rd0", 2'd0, 32'h0);
    chk_rd("reset_rd1", 2'd1, 32'h0);
    chk_rd("reset_rd2", 2'd2, 32'h0);

    // ---- register map vectors ----
    tbl[0] = '{1'b1, 1'b1, 2'd2, 12'hABC, 32'h0,   12'hABC};
    tbl[1] = '{1'b1, 1'b0, 2'd2, 12'h000, 32'hABC, 12'hABC};
    tbl[2] = '{1'b0, 1'b0, 2'd2, 12'h000, 32'h0,   12'hABC};
    tbl[3] = '{1'b1, 1'b1, 2'd1, 12'hFFF, 32'h0,   12'hABC};
    tbl[4] = '{1'b1, 1'b1, 2'd3, 12'h555, 32'h0,   12'hABC};
    tbl[5] = '{1'b1, 1'b0, 2'd3, 12'h000, 32'h0,   12'hABC};
    tbl[6] = '{1'b1, 1'b1, 2'd0, 12'hFFF, 32'h0,   12'hABC};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 12'h000, 32'hABC, 12'h000};
    tbl[8] = '{1'b1, 1'b0, 2'd2, 12'h000, 32'h0,   12'h000};
    for (int i = 0; i < 9; i++) begin
      pRead = tbl[i].rd; pWrite = tbl[i].wr; addr = tbl[i].a; pWriteData = tbl[i].wd;
      #1;
      chk("tbl_rdata", pReadData, tbl[i].exp_rd);
      tick();
      chk("tbl_led", {20'b0, led}, {20'b0, tbl[i].exp_led});
    end
    pWrite = 1'b0;

    // ---- switch capture: sw_ready rises exactly 2+D+1 edges after the raw edge ----
    switch = 16'hA5C3; buttonR = 1'b1; pRead = 1'b1; addr = 2'd0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("capture_latency", pReadData, (k >= 2 + D + 1) ? 32'h1 : 32'h0);
    end
    buttonR = 1'b0;
    ticks(10);
    chk_rd("capture_sw", 2'd1, 32'h0000A5C3);
    chk_rd("capture_status", 2'd0, 32'h1);

    // ---- glitch rejection ----
    wr(2'd0, 12'h001);
    switch = 16'h1234; buttonR = 1'b1;
    ticks(D - 1);
    buttonR = 1'b0;
    ticks(10);
    chk_rd("glitch_status", 2'd0, 32'h0);
    chk_rd("glitch_sw", 2'd1, 32'h0000A5C3);

    // ---- LED handshake ----
    wr(2'd2, 12'hABC);
    chk("hs_led", {20'b0, led}, 32'hABC);
    chk_rd("hs_status_after_write", 2'd0, 32'h0);
    buttonL = 1'b1;
    ticks(10);
    buttonL = 1'b0;
    ticks(8);
    chk_rd("hs_status_pressed", 2'd0, 32'h2);
    wr(2'd0, 12'h002);
    chk_rd("hs_status_cleared", 2'd0, 32'h0);

    // ---- collisions: press pulse in the same cycle as a clearing write ----
    for (int c = 0; c < 2; c++) begin
      wr(2'd0, 12'h003);
      if (c == 0) buttonR = 1'b1; else buttonL = 1'b1;
      ticks(2 + D);
      if (c == 0) wr(2'd0, 12'h001); else wr(2'd2, 12'h5A5);
      chk_rd("collide_status", 2'd0, (c == 0) ? 32'h1 : 32'h2);
      if (c == 1) chk("collide_led", {20'b0, led}, 32'h5A5);
      buttonR = 1'b0; buttonL = 1'b0;
      ticks(10);
    end

    // ---- reset in the middle of a debounce ----
    wr(2'd0, 12'h003);
    buttonL = 1'b1; pRead = 1'b1; addr = 2'd0;
    ticks(4);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("midreset_in_reset", pReadData, 32'h0);
    end
    reset = 1'b0;
    rise_at = 0; rises = 0; prev = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pReadData[1] && !prev) begin
        rises++;
        if (rise_at == 0) rise_at = i;
      end
      prev = pReadData[1];
    end
    chk("midreset_rise_count", rises, 1);
    chk("midreset_rise_late", (rise_at >= D) ? 1 : 0, 1);
    buttonL = 1'b0;
    ticks(10);

    // ---- randomized traffic against the model ----
    hold_l = 0; hold_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_l == 0) begin buttonL = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 8); end
      if (hold_r == 0) begin buttonR = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 8); end
      hold_l--; hold_r--;
      if ($urandom_range(0, 3) == 0) switch = 16'($urandom);
      pRead      = 1'($urandom_range(0, 1));
      pWrite     = ($urandom_range(0, 5) == 0);
      addr       = 2'($urandom_range(0, 3));
      pWriteData = 12'($urandom);
      reset      = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0; pWrite = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
